// File: rtl/uart_sram_tx_interface_pkg.sv
// rtl/uart_sram_tx_interface_pkg.sv - shared types and constants for the SRAM-to-UART dump engine
package uart_sram_tx_interface_pkg;

  localparam int UART_CLKS_PER_BIT = 434;
  localparam int SRAM_ADDR_W       = 18;
  localparam int SRAM_DATA_W       = 16;

  typedef enum logic [3:0] {
    S_TX_IDLE,
    S_TX_REQ,
    S_TX_WAIT_DATA,
    S_TX_SEND_HI,
    S_TX_WAIT_HI,
    S_TX_SEND_LO,
    S_TX_WAIT_LO,
    S_TX_NEXT,
    S_TX_DONE
  } tx_state_type;

  // Words go out high byte first.
  function automatic logic [7:0] word_byte(input logic [SRAM_DATA_W-1:0] word, input logic high);
    return high ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_if.sv
// rtl/uart_sram_tx_interface_if.sv - SRAM controller read port used by the dump engine
interface uart_sram_tx_interface_if;
  import uart_sram_tx_interface_pkg::*;

  logic [SRAM_ADDR_W-1:0] SRAM_address;
  logic [SRAM_DATA_W-1:0] SRAM_read_data;
  logic                   SRAM_we_n;

  modport master (
    output SRAM_address,
    output SRAM_we_n,
    input  SRAM_read_data
  );

  modport slave (
    input  SRAM_address,
    input  SRAM_we_n,
    output SRAM_read_data
  );

endinterface

// File: rtl/uart_sram_tx_interface_uart_tx_byte.sv
// rtl/uart_sram_tx_interface_uart_tx_byte.sv - 8N1 byte serializer with load/busy handshake
module uart_tx_byte
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_line
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [7:0]        shift_reg;

  // bit_cnt is the frame position on the line: 0 start, 1..8 data, 9 stop.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tx_busy   <= 1'b0;
      tx_line   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (!tx_busy) begin
      if (tx_load) begin
        tx_busy   <= 1'b1;
        tx_line   <= 1'b0;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        shift_reg <= tx_data;
      end
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd8) begin
          tx_line <= 1'b1;
        end else begin
          tx_line   <= shift_reg[0];
          shift_reg <= {1'b0, shift_reg[7:1]};
        end
      end
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// rtl/uart_sram_tx_interface.sv - reads an SRAM word range and dumps it over UART, high byte first
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT      = UART_CLKS_PER_BIT,
  parameter int SRAM_READ_LATENCY = 2
) (
  input  logic                      CLOCK_50_I,
  input  logic                      resetn,
  input  logic                      Start,
  input  logic                      Stop,
  input  logic [SRAM_ADDR_W-1:0]    Start_address,
  input  logic [SRAM_ADDR_W-1:0]    End_address,
  uart_sram_tx_interface_if.master  sram_bus,
  output logic                      UART_TX_O,
  output logic                      Busy,
  output logic                      Done,
  output logic [SRAM_ADDR_W-1:0]    Word_count
);

  localparam int LAT_W = (SRAM_READ_LATENCY > 0) ? $clog2(SRAM_READ_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(SRAM_READ_LATENCY);

  tx_state_type state, state_next;

  logic [SRAM_ADDR_W-1:0] cur_addr;
  logic [SRAM_ADDR_W-1:0] end_addr;
  logic [SRAM_ADDR_W-1:0] sram_addr_q;
  logic [LAT_W-1:0]       lat_cnt;
  logic [SRAM_DATA_W-1:0] data_reg;
  logic                   stop_seen;
  logic                   tx_load;
  logic                   tx_busy;
  logic [7:0]             tx_data;

  assign sram_bus.SRAM_address = sram_addr_q;
  assign sram_bus.SRAM_we_n    = 1'b1;
  assign tx_data               = word_byte(data_reg, state == S_TX_SEND_HI);

  always_comb begin
    state_next = state;
    tx_load    = 1'b0;
    case (state)
      S_TX_IDLE:
        if (Start) state_next = (Start_address > End_address) ? S_TX_DONE : S_TX_REQ;
      S_TX_REQ:
        state_next = S_TX_WAIT_DATA;
      S_TX_WAIT_DATA:
        if (lat_cnt == LAT_LAST) state_next = S_TX_SEND_HI;
      S_TX_SEND_HI: begin
        tx_load = 1'b1;
        if (!tx_busy) state_next = S_TX_WAIT_HI;
      end
      // A stop request after the high byte abandons the word uncounted.
      S_TX_WAIT_HI:
        if (!tx_busy) state_next = (stop_seen || Stop) ? S_TX_DONE : S_TX_SEND_LO;
      S_TX_SEND_LO: begin
        tx_load = 1'b1;
        if (!tx_busy) state_next = S_TX_WAIT_LO;
      end
      S_TX_WAIT_LO:
        if (!tx_busy) state_next = S_TX_NEXT;
      S_TX_NEXT:
        state_next = (cur_addr == end_addr || stop_seen || Stop) ? S_TX_DONE : S_TX_REQ;
      S_TX_DONE:
        state_next = S_TX_IDLE;
      default:
        state_next = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state       <= S_TX_IDLE;
      cur_addr    <= '0;
      end_addr    <= '0;
      sram_addr_q <= '0;
      lat_cnt     <= '0;
      data_reg    <= '0;
      stop_seen   <= 1'b0;
      Word_count  <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      state <= state_next;
      Done  <= 1'b0;
      case (state)
        S_TX_IDLE:
          if (Start) begin
            cur_addr   <= Start_address;
            end_addr   <= End_address;
            Word_count <= '0;
            Busy       <= 1'b1;
            stop_seen  <= 1'b0;
          end
        S_TX_REQ: begin
          sram_addr_q <= cur_addr;
          lat_cnt     <= '0;
        end
        S_TX_WAIT_DATA: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LAT_LAST) data_reg <= sram_bus.SRAM_read_data;
        end
        S_TX_WAIT_HI, S_TX_WAIT_LO:
          if (Stop) stop_seen <= 1'b1;
        // The address only advances when another word follows, so 3FFFF never wraps.
        S_TX_NEXT: begin
          Word_count <= Word_count + 1'b1;
          if (state_next == S_TX_REQ) cur_addr <= cur_addr + 1'b1;
        end
        S_TX_DONE: begin
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clock   (CLOCK_50_I),
    .resetn  (resetn),
    .tx_load (tx_load),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx_line (UART_TX_O)
  );

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// tb/tb_uart_sram_tx_interface.sv - scoreboard bench for the SRAM-to-UART dump engine
module tb_uart_sram_tx_interface;

  localparam int CPB = 4;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] End_address = '0;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;
  logic [17:0] Word_count;

  uart_sram_tx_interface_if sram_if ();

  uart_sram_tx_interface #(
    .CLKS_PER_BIT      (CPB),
    .SRAM_READ_LATENCY (2)
  ) dut (
    .CLOCK_50_I    (CLOCK_50_I),
    .resetn        (resetn),
    .Start         (Start),
    .Stop          (Stop),
    .Start_address (Start_address),
    .End_address   (End_address),
    .sram_bus      (sram_if),
    .UART_TX_O     (UART_TX_O),
    .Busy          (Busy),
    .Done          (Done),
    .Word_count    (Word_count)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  typedef struct {
    logic [17:0] count;
    bit          empty;
  } done_exp_t;

  logic [7:0]  byte_q[$];
  done_exp_t   done_q[$];
  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_pipe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_started = 0;
  int busy_rise_cyc = 0;
  int we_bad = 0;

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[7:0], ~a[7:0]} ^ 16'h3C5A;
  endfunction

  // Behavioural SRAM: data appears two cycles after the address.
  always @(posedge CLOCK_50_I) begin
    rd_pipe <= mem_rd(sram_if.SRAM_address);
    sram_if.SRAM_read_data <= rd_pipe;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every word in range gives hi then lo; a stop in word stop_word keeps only its hi byte.
  task automatic expect_dump(input logic [17:0] sa, input logic [17:0] ea, input int stop_word);
    int n;
    done_exp_t e;
    logic [15:0] w;
    n = 0;
    if (sa > ea) begin
      e.count = '0;
      e.empty = 1'b1;
      done_q.push_back(e);
      return;
    end
    for (int a = int'(sa); a <= int'(ea); a++) begin
      w = mem_rd(18'(a));
      byte_q.push_back(w[15:8]);
      if (stop_word == n) break;
      byte_q.push_back(w[7:0]);
      n++;
    end
    e.count = 18'(n);
    e.empty = 1'b0;
    done_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [17:0] sa, input logic [17:0] ea);
    @(posedge CLOCK_50_I);
    #1;
    Start_address = sa;
    End_address   = ea;
    Start         = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((done_q.size() != 0 || Busy) && n < 6000) begin
      @(posedge CLOCK_50_I);
      n++;
    end
    checks++;
    if (n >= 6000) begin
      errors++;
      $display("FAIL %s timeout busy=%0b pending_done=%0d expected idle", name, Busy, done_q.size());
    end
    repeat (4) @(posedge CLOCK_50_I);
  endtask

  task automatic wait_frames(input string name, input int target);
    int n;
    n = 0;
    while (frames_started < target && n < 4000) begin
      @(posedge CLOCK_50_I);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL %s timeout frames=%0d expected %0d", name, frames_started, target);
    end
  endtask

  // UART monitor: decodes each frame sample by sample and checks it against the scoreboard.
  logic       mon_prev = 1'b1;
  logic [9:0] bit_val;
  logic       stable;
  logic       aborted;
  logic       have_exp;
  logic [7:0] exp_b;

  initial begin
    forever begin
      @(negedge CLOCK_50_I);
      if (resetn && mon_prev && !UART_TX_O) begin
        frames_started++;
        have_exp = byte_q.size() > 0;
        exp_b    = have_exp ? byte_q.pop_front() : 8'h00;
        stable   = 1'b1;
        aborted  = 1'b0;
        bit_val  = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge CLOCK_50_I);
            if (!resetn) aborted = 1'b1;
            else if (c == 0) bit_val[b] = UART_TX_O;
            else if (UART_TX_O !== bit_val[b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          checks++;
          if (!have_exp) begin
            errors++;
            $display("FAIL uart_frame got unexpected byte=%02h expected no frame", bit_val[8:1]);
          end else if (bit_val[8:1] !== exp_b || bit_val[0] !== 1'b0 || bit_val[9] !== 1'b1 || !stable) begin
            errors++;
            $display("FAIL uart_frame got byte=%02h start=%0b stop=%0b stable=%0b expected byte=%02h start=0 stop=1 stable=1",
                     bit_val[8:1], bit_val[0], bit_val[9], stable, exp_b);
          end
        end
      end
      mon_prev = UART_TX_O;
    end
  end

  // Completion monitor: Done width, Word_count, Busy and the empty-range timing.
  logic      busy_prev = 1'b0;
  logic      done_prev = 1'b0;
  done_exp_t de;

  initial begin
    forever begin
      @(negedge CLOCK_50_I);
      if (sram_if.SRAM_we_n !== 1'b1) we_bad++;
      if (Busy && !busy_prev) busy_rise_cyc = cyc;
      busy_prev = Busy;
      if (Done) begin
        checks++;
        if (done_prev) begin
          errors++;
          $display("FAIL done_width got Done high 2+ cycles expected 1");
        end else if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got Done pulse expected none");
        end else begin
          de = done_q.pop_front();
          if (Word_count !== de.count || Busy !== 1'b0 || byte_q.size() != 0 ||
              (de.empty && (cyc - busy_rise_cyc) != 1)) begin
            errors++;
            $display("FAIL done got word_count=%0d busy=%0b bytes_left=%0d busy_to_done=%0d expected word_count=%0d busy=0 bytes_left=0 busy_to_done=%0s",
                     Word_count, Busy, byte_q.size(), cyc - busy_rise_cyc, de.count, de.empty ? "1" : "any");
          end
        end
      end
      done_prev = Done;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [17:0] rsa;
  int          rlen;
  int          base;

  initial begin
    repeat (3) @(posedge CLOCK_50_I);
    #1;
    check("reset_uart_tx", UART_TX_O, 1);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_sram_address", sram_if.SRAM_address, 0);
    check("reset_word_count", Word_count, 0);
    check("reset_we_n", sram_if.SRAM_we_n, 1);
    resetn = 1'b1;

    mem[18'd0] = 16'hA55A;
    expect_dump(18'd0, 18'd0, -1);
    pulse_start(18'd0, 18'd0);
    wait_idle("single_word");

    for (int i = 0; i < 4; i++) mem[18'(10 + i)] = 16'h0100 + 16'(i);
    expect_dump(18'd10, 18'd13, -1);
    pulse_start(18'd10, 18'd13);
    wait_idle("four_words");

    expect_dump(18'd5, 18'd4, -1);
    pulse_start(18'd5, 18'd4);
    wait_idle("empty_range");
    repeat (60) @(posedge CLOCK_50_I);

    for (int i = 0; i < 10; i++) mem[18'(i)] = 16'($urandom);
    expect_dump(18'd0, 18'd9, 2);
    base = frames_started;
    pulse_start(18'd0, 18'd9);
    wait_frames("stop_reach_word2", base + 5);
    repeat (6) @(posedge CLOCK_50_I);
    #1;
    Stop = 1'b1;
    wait_idle("stop_mid_high");
    Stop = 1'b0;

    for (int i = 0; i < 6; i++) mem[18'(30 + i)] = 16'($urandom);
    expect_dump(18'd30, 18'd35, -1);
    pulse_start(18'd30, 18'd35);
    repeat (20) @(posedge CLOCK_50_I);
    pulse_start(18'd100, 18'd101);
    repeat (200) @(posedge CLOCK_50_I);
    pulse_start(18'd0, 18'd0);
    wait_idle("restart_ignored");

    mem[18'h3FFFE] = 16'($urandom);
    mem[18'h3FFFF] = 16'($urandom);
    expect_dump(18'h3FFFE, 18'h3FFFF, -1);
    pulse_start(18'h3FFFE, 18'h3FFFF);
    wait_idle("top_of_memory");
    expect_dump(18'h3FFFF, 18'h3FFFF, -1);
    pulse_start(18'h3FFFF, 18'h3FFFF);
    wait_idle("last_word_only");

    for (int t = 0; t < 5; t++) begin
      rsa  = 18'($urandom_range(0, 262139));
      rlen = int'($urandom_range(0, 3));
      for (int i = 0; i <= rlen; i++) mem[rsa + 18'(i)] = 16'($urandom);
      expect_dump(rsa, rsa + 18'(rlen), -1);
      pulse_start(rsa, rsa + 18'(rlen));
      wait_idle("random_range");
    end

    for (int i = 0; i < 3; i++) mem[18'(20 + i)] = 16'($urandom);
    expect_dump(18'd20, 18'd22, -1);
    base = frames_started;
    pulse_start(18'd20, 18'd22);
    wait_frames("reset_reach_frame", base + 2);
    repeat (3) @(posedge CLOCK_50_I);
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_uart_tx", UART_TX_O, 1);
    check("async_reset_busy", Busy, 0);
    byte_q.delete();
    done_q.delete();
    repeat (3) @(posedge CLOCK_50_I);
    #1;
    resetn = 1'b1;
    check("post_reset_word_count", Word_count, 0);
    check("post_reset_sram_address", sram_if.SRAM_address, 0);
    expect_dump(18'd20, 18'd22, -1);
    pulse_start(18'd20, 18'd22);
    wait_idle("dump_after_reset");

    check("we_n_low_cycles", we_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
